// File: rtl/clause_stream_reader_if.sv
// Bus bundle between the clause stream reader, the clause bank and the evaluator.
// Carries sweep control, the bank read port and the clause output stream.
// master = the reader itself, slave = the surrounding bank/evaluator side.
interface clause_stream_reader_if #(
  parameter int COEFF_WIDTH = 4,
  parameter int NUM_VARS    = 4,
  parameter int IDX_W       = 3
);
  // sweep control
  logic                              in_start;
  logic                              in_abort;
  logic [IDX_W:0]                    in_clause_count;
  // bank read port
  logic                              out_read_enable;
  logic [IDX_W-1:0]                  out_read_address;
  logic [COEFF_WIDTH*NUM_VARS-1:0]   in_read_data;
  // clause output stream
  logic [COEFF_WIDTH*NUM_VARS-1:0]   out_clause_coefficients;
  logic [IDX_W-1:0]                  out_clause_index;
  logic                              out_valid;
  logic                              in_ready;
  // status
  logic                              out_busy;
  logic                              out_done;

  modport master (
    input  in_start,
    input  in_abort,
    input  in_clause_count,
    output out_read_enable,
    output out_read_address,
    input  in_read_data,
    output out_clause_coefficients,
    output out_clause_index,
    output out_valid,
    input  in_ready,
    output out_busy,
    output out_done
  );

  modport slave (
    output in_start,
    output in_abort,
    output in_clause_count,
    input  out_read_enable,
    input  out_read_address,
    output in_read_data,
    input  out_clause_coefficients,
    input  out_clause_index,
    input  out_valid,
    output in_ready,
    input  out_busy,
    input  out_done
  );
endinterface

// File: rtl/clause_stream_reader.sv
// Purpose: sweeps clause addresses 0..count-1 and streams each clause vector with its index.
// Latency: first clause valid 2 cycles after start is sampled; 1 clause/cycle with ready held high.
// Backpressure: reads stall once buffered + inflight clauses reach 2; head held stable while stalled.
module clause_stream_reader #(
  parameter int COEFF_WIDTH = 4,
  parameter int NUM_VARS    = 4,
  parameter int NUM_CLAUSES = 8,
  parameter int IDX_W       = 3
) (
  input  logic                  in_clk,
  input  logic                  in_reset_n,
  clause_stream_reader_if.master bus
);

  localparam int DW = COEFF_WIDTH * NUM_VARS;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [IDX_W:0] MAX_COUNT = NUM_CLAUSES[IDX_W:0];
  localparam logic [IDX_W:0] ONE       = {{IDX_W{1'b0}}, 1'b1};

  // sweep control state
  logic [1:0]       state_q;
  logic [IDX_W:0]   count_q;
  logic [IDX_W:0]   issue_ptr_q;
  logic             done_q;

  // one read can be in flight; its address travels with it as the FIFO tag
  logic             inflight_q;
  logic [IDX_W-1:0] inflight_idx_q;

  // 2-entry clause FIFO
  logic [DW-1:0]    fifo_dat_q [2];
  logic [IDX_W-1:0] fifo_idx_q [2];
  logic             fifo_rd_ptr_q;
  logic             fifo_wr_ptr_q;
  logic [1:0]       fifo_occ_q;

  // combinational decisions
  logic [IDX_W:0]   clamped_count;
  logic [IDX_W:0]   count_m1;
  logic [2:0]       credit_used;
  logic             credit_ok;
  logic             head_vld;
  logic             pop;
  logic             push;
  logic             issue;
  logic             last_issue;
  logic             last_pop;
  logic             start_ok;

  // Per-cycle decisions: clamp, credit check, read issue and end-of-sweep detection.
  always_comb begin
    clamped_count = (bus.in_clause_count > MAX_COUNT) ? MAX_COUNT : bus.in_clause_count;
    count_m1      = count_q - ONE;
    head_vld      = (fifo_occ_q != 2'd0);
    pop           = head_vld && bus.in_ready;
    push          = inflight_q;
    // A slot freed by this cycle's pop can be reused by a read issued this cycle.
    credit_used   = {1'b0, fifo_occ_q} + {2'b00, inflight_q};
    credit_ok     = (credit_used < (3'd2 + {2'b00, pop}));
    issue         = (state_q == ST_FETCH) && !bus.in_abort && credit_ok;
    last_issue    = issue && (issue_ptr_q == count_m1);
    last_pop      = (state_q == ST_DRAIN) && pop &&
                    ({1'b0, fifo_idx_q[fifo_rd_ptr_q]} == count_m1);
    start_ok      = (state_q == ST_IDLE) && bus.in_start && !bus.in_abort;
  end

  // Sweep FSM: latch the clamped count on start, walk the issue pointer, wait for the last transfer.
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      issue_ptr_q <= '0;
    end else if (bus.in_abort) begin
      state_q     <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            count_q     <= clamped_count;
            issue_ptr_q <= '0;
            state_q     <= (clamped_count == '0) ? ST_IDLE : ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (issue) begin
            issue_ptr_q <= issue_ptr_q + ONE;
            if (last_issue) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (last_pop) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Done pulse: the cycle after an empty sweep starts or after the final clause leaves.
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= !bus.in_abort && ((start_ok && (clamped_count == '0)) || last_pop);
    end
  end

  // Inflight tracker: bank data for a strobe arrives one cycle later; abort drops it.
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      inflight_q     <= 1'b0;
      inflight_idx_q <= '0;
    end else if (bus.in_abort) begin
      inflight_q     <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_idx_q <= issue_ptr_q[IDX_W-1:0];
      end
    end
  end

  // Clause FIFO: push returned data with its address tag, pop on transfer, abort empties it.
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_dat_q[i] <= '0;
        fifo_idx_q[i] <= '0;
      end
      fifo_rd_ptr_q <= 1'b0;
      fifo_wr_ptr_q <= 1'b0;
      fifo_occ_q    <= 2'd0;
    end else if (bus.in_abort) begin
      fifo_rd_ptr_q <= 1'b0;
      fifo_wr_ptr_q <= 1'b0;
      fifo_occ_q    <= 2'd0;
    end else begin
      if (push) begin
        fifo_dat_q[fifo_wr_ptr_q] <= bus.in_read_data;
        fifo_idx_q[fifo_wr_ptr_q] <= inflight_idx_q;
        fifo_wr_ptr_q             <= ~fifo_wr_ptr_q;
      end
      if (pop) begin
        fifo_rd_ptr_q <= ~fifo_rd_ptr_q;
      end
      fifo_occ_q <= fifo_occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign bus.out_read_enable         = issue;
  assign bus.out_read_address        = issue ? issue_ptr_q[IDX_W-1:0] : '0;
  assign bus.out_clause_coefficients = fifo_dat_q[fifo_rd_ptr_q];
  assign bus.out_clause_index        = fifo_idx_q[fifo_rd_ptr_q];
  assign bus.out_valid               = head_vld;
  assign bus.out_busy                = (state_q != ST_IDLE);
  assign bus.out_done                = done_q;

endmodule
